// File: rtl/my_adder_pkg.sv
// Shared definitions for the serial adder: state encoding and default operand width.
package my_adder_pkg;

  localparam logic [1:0]  ST_IDLE       = 2'd0;
  localparam logic [1:0]  ST_RUN        = 2'd1;
  localparam logic [1:0]  ST_DONE       = 2'd2;
  localparam int unsigned ADD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    SA_IDLE = ST_IDLE,
    SA_RUN  = ST_RUN,
    SA_DONE = ST_DONE
  } sa_state_e;

endpackage

// File: rtl/my_serial_adder_if.sv
// Request/result bundle of the bit-serial adder; Ov exists only when SERIAL_ADD_OVF_EN is defined.
interface my_serial_adder_if
  import my_adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;
`ifdef SERIAL_ADD_OVF_EN
  logic             Ov;
`endif

  modport master (
    output start, A, B, Ci,
`ifdef SERIAL_ADD_OVF_EN
    input  Ov,
`endif
    input  busy, done, S, Co
  );

  modport slave (
    input  start, A, B, Ci,
`ifdef SERIAL_ADD_OVF_EN
    output Ov,
`endif
    output busy, done, S, Co
  );

endinterface

// File: rtl/my_fadder2.sv
// Single-bit combinational full adder cell.
module my_fadder2 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/my_serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder stage per clock.
// Optional signed-overflow output Ov under macro SERIAL_ADD_OVF_EN.
module my_serial_adder
  import my_adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  my_serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_co;
  logic             load_c, run_c, last_c;
  logic             busy_q, done_q, co_q;
  logic [WIDTH-1:0] s_q;

  my_fadder2 fa0 (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (cy),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SA_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    run_c   = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      SA_IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = SA_RUN;
        end
      end
      SA_RUN: begin
        run_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_d = SA_DONE;
        end
      end
      SA_DONE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = SA_RUN;
        end else begin
          state_d = SA_IDLE;
        end
      end
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      s_q    <= '0;
      co_q   <= 1'b0;
    end else begin
      busy_q <= (state_d == SA_RUN);
      done_q <= last_c;
      if (load_c) begin
        a_sr <= bus.A;
        b_sr <= bus.B;
        cy   <= bus.Ci;
        cnt  <= '0;
        s_sr <= '0;
      end else if (run_c) begin
        a_sr <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr <= {1'b0, b_sr[WIDTH-1:1]};
        s_sr <= {fa_s, s_sr[WIDTH-1:1]};
        cy   <= fa_co;
        cnt  <= cnt + CNT_W'(1);
      end
      // Result registers only move on the last bit, so they are never partial
      if (last_c) begin
        s_q  <= {fa_s, s_sr[WIDTH-1:1]};
        co_q <= fa_co;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ov_q;

  // Carry into the MSB differs from carry out of it on signed overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ov_q <= 1'b0;
    else if (last_c) ov_q <= cy ^ fa_co;
  end

  assign bus.Ov = ov_q;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Co   = co_q;

endmodule
